// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcode/funct
// values and the ALU operation codes used by the datapath and ALU bench.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } statetype;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOT = 6'b100111;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_if.sv
// Control/status bundle between the multicycle controller (master) and the
// shared-ALU datapath (slave).
interface mc_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state_dbg
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state_dbg
    );
endinterface

// File: rtl/mc_aludec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o,
    output logic       legal_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        legal_o      = 1'b1;
        case (funct_i)
            FN_ADD:  alucontrol_o = ALU_ADD;
            FN_AND:  alucontrol_o = ALU_AND;
            FN_NOT:  alucontrol_o = ALU_NOT;
            FN_SUB:  alucontrol_o = ALU_SUB;
            FN_SLT:  alucontrol_o = ALU_SLT;
            default: legal_o      = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the shared-ALU multicycle datapath; pcen is the only Mealy output.
// state | meaning: 0 FETCH | 1 DECODE | 2 MEMADR | 3 MEMRD | 4 MEMWB | 5 MEMWR
//                  6 EXECUTE | 7 ALUWB | 8 BRANCH | 9 ADDIEX | 10 ADDIWB | 11 JUMP
module mc_controller
    import mc_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    mc_if.master  bus
);

    localparam logic [3:0] S_FETCH   = FETCH;
    localparam logic [3:0] S_DECODE  = DECODE;
    localparam logic [3:0] S_MEMADR  = MEMADR;
    localparam logic [3:0] S_MEMRD   = MEMRD;
    localparam logic [3:0] S_MEMWB   = MEMWB;
    localparam logic [3:0] S_MEMWR   = MEMWR;
    localparam logic [3:0] S_EXECUTE = EXECUTE;
    localparam logic [3:0] S_ALUWB   = ALUWB;
    localparam logic [3:0] S_BRANCH  = BRANCH;
    localparam logic [3:0] S_ADDIEX  = ADDIEX;
    localparam logic [3:0] S_ADDIWB  = ADDIWB;
    localparam logic [3:0] S_JUMP    = JUMP;

    logic [3:0] state_q, state_d;
    logic       is_lw_q, is_lw_d;

    logic       pcwrite_c, branch_c;
    logic       irwrite_c, iord_c, memwrite_c, regwrite_c;
    logic       regdst_c, memtoreg_c, alusrca_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] alucontrol_c;

    logic [2:0] fn_alu;
    logic       fn_legal;

    mc_aludec u_aludec (
        .funct_i      (bus.funct),
        .alucontrol_o (fn_alu),
        .legal_o      (fn_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        is_lw_d      = is_lw_q;
        pcwrite_c    = 1'b0;
        branch_c     = 1'b0;
        irwrite_c    = 1'b0;
        iord_c       = 1'b0;
        memwrite_c   = 1'b0;
        regwrite_c   = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        alucontrol_c = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                irwrite_c = 1'b1;
                pcwrite_c = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                // op is only trusted here, so remember load-vs-store for MEMADR
                is_lw_d   = (bus.op == OP_LW);
                if (is_mem_op(bus.op)) begin
                    state_d = S_MEMADR;
                end else begin
                    case (bus.op)
                        OP_RTYPE: state_d = fn_legal ? S_EXECUTE : S_FETCH;
                        OP_BEQ:   state_d = S_BRANCH;
                        OP_ADDI:  state_d = S_ADDIEX;
                        OP_J:     state_d = S_JUMP;
                        default:  state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = is_lw_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_c    = 1'b1;
                alucontrol_c = fn_alu;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = 2'b01;
                branch_c     = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
            end
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset gates the enables directly so a pending write dies in the cycle reset rises.
    assign bus.pcen       = ~reset & (pcwrite_c | (branch_c & bus.zero));
    assign bus.irwrite    = ~reset & irwrite_c;
    assign bus.memwrite   = ~reset & memwrite_c;
    assign bus.regwrite   = ~reset & regwrite_c;
    assign bus.iord       = iord_c;
    assign bus.regdst     = regdst_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.alucontrol = alucontrol_c;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control vectors are queued
// with the stimulus and compared at each falling edge.
module tb_mc_controller;

    logic clk;
    logic reset;
    mc_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                           ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                           ST_EXEC = 4'd6, ST_ALUWB = 4'd7, ST_BRANCH = 4'd8,
                           ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        z;
        logic [18:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  passed = 0;

    // {state, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol}
    function automatic logic [18:0] outs(input logic [3:0] st, input logic [2:0] alu, input logic z);
        logic pe, ir, io, mw, rw, rd, m2r, sa;
        logic [1:0] sbv, ps;
        logic [2:0] ac;
        {pe, ir, io, mw, rw, rd, m2r, sa} = 8'b0;
        sbv = 2'b00; ps = 2'b00; ac = 3'b000;
        case (st)
            ST_FETCH:  begin sbv = 2'b01; ir = 1'b1; pe = 1'b1; end
            ST_DECODE: sbv = 2'b11;
            ST_MEMADR: begin sa = 1'b1; sbv = 2'b10; end
            ST_MEMRD:  io = 1'b1;
            ST_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
            ST_MEMWR:  begin io = 1'b1; mw = 1'b1; end
            ST_EXEC:   begin sa = 1'b1; ac = alu; end
            ST_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
            ST_BRANCH: begin sa = 1'b1; ac = 3'b011; ps = 2'b01; pe = z; end
            ST_ADDIEX: begin sa = 1'b1; sbv = 2'b10; end
            ST_ADDIWB: rw = 1'b1;
            ST_JUMP:   begin ps = 2'b10; pe = 1'b1; end
            default:   ;
        endcase
        return {st, pe, ir, io, mw, rw, rd, m2r, sa, sbv, ps, ac};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.state_dbg, bus.pcen, bus.irwrite, bus.iord, bus.memwrite, bus.regwrite,
                bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};
    endfunction

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic [3:0] st, input logic [2:0] alu);
        sb_t e;
        e.op = o; e.funct = f; e.z = z; e.exp = outs(st, alu, z);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [18:0] got;
        reset = 1'b1;
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.state_dbg, bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite} !== 8'b0)
            $display("FAIL reset_hold: got %b expected %b",
                     {bus.state_dbg, bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite}, 8'b0);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        bus.zero = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== outs(ST_FETCH, 3'b000, 1'b0))
            $display("FAIL reset_release_fetch: got %h expected %h", got, outs(ST_FETCH, 3'b000, 1'b0));
        else passed++;
    endtask

    task automatic test_lw();
        sb_t e;
        logic [18:0] got;
        push(6'b100011, 6'b0, 1'b0, ST_FETCH, 3'b000);
        push(6'b100011, 6'b0, 1'b0, ST_DECODE, 3'b000);
        // op changes after DECODE must not redirect the load
        push(6'b101011, 6'b0, 1'b1, ST_MEMADR, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_MEMRD, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_MEMWB, 3'b000);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            bus.op = e.op; bus.funct = e.funct; bus.zero = e.z;
            #1;
            got = observed();
            checks++;
            if (got !== e.exp) $display("FAIL lw step %0d: got %h expected %h", i, got, e.exp);
            else passed++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        sb_t e;
        logic [18:0] got;
        logic [5:0] fn [5] = '{6'b100000, 6'b100100, 6'b100111, 6'b100010, 6'b101010};
        logic [2:0] ac [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        for (int k = 0; k < 5; k++) begin
            push(6'b000000, fn[k], 1'b0, ST_FETCH, 3'b000);
            push(6'b000000, fn[k], 1'b1, ST_DECODE, 3'b000);
            push(6'b000000, fn[k], 1'b1, ST_EXEC, ac[k]);
            push(6'b000000, fn[k], 1'b0, ST_ALUWB, 3'b000);
        end
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            bus.op = e.op; bus.funct = e.funct; bus.zero = e.z;
            #1;
            got = observed();
            checks++;
            if (got !== e.exp) $display("FAIL rtype step %0d: got %h expected %h", i, got, e.exp);
            else passed++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_beq();
        sb_t e;
        logic [18:0] got;
        push(6'b000100, 6'b0, 1'b1, ST_FETCH, 3'b000);
        push(6'b000100, 6'b0, 1'b1, ST_DECODE, 3'b000);
        push(6'b000100, 6'b0, 1'b1, ST_BRANCH, 3'b000);
        push(6'b000100, 6'b0, 1'b0, ST_FETCH, 3'b000);
        push(6'b000100, 6'b0, 1'b1, ST_DECODE, 3'b000);
        push(6'b000100, 6'b0, 1'b0, ST_BRANCH, 3'b000);
        push(6'b001000, 6'b0, 1'b1, ST_FETCH, 3'b000);
        push(6'b001000, 6'b0, 1'b1, ST_DECODE, 3'b000);
        push(6'b001000, 6'b0, 1'b1, ST_ADDIEX, 3'b000);
        push(6'b001000, 6'b0, 1'b1, ST_ADDIWB, 3'b000);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            bus.op = e.op; bus.funct = e.funct; bus.zero = e.z;
            #1;
            got = observed();
            checks++;
            if (got !== e.exp) $display("FAIL beq_addi step %0d: got %h expected %h", i, got, e.exp);
            else passed++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        sb_t e;
        logic [18:0] got;
        push(6'b111111, 6'b0, 1'b0, ST_FETCH, 3'b000);
        push(6'b111111, 6'b0, 1'b1, ST_DECODE, 3'b000);
        push(6'b000000, 6'b000001, 1'b0, ST_FETCH, 3'b000);
        push(6'b000000, 6'b000001, 1'b1, ST_DECODE, 3'b000);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            bus.op = e.op; bus.funct = e.funct; bus.zero = e.z;
            #1;
            got = observed();
            checks++;
            if (got !== e.exp) $display("FAIL illegal step %0d: got %h expected %h", i, got, e.exp);
            else passed++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset_midwrite();
        sb_t e;
        logic [18:0] got;
        push(6'b101011, 6'b0, 1'b0, ST_FETCH, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_DECODE, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_MEMADR, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_MEMWR, 3'b000);
        while (sb.size() > 1) begin
            e = sb.pop_front();
            bus.op = e.op; bus.funct = e.funct; bus.zero = e.z;
            #1;
            got = observed();
            checks++;
            if (got !== e.exp) $display("FAIL midreset_lead: got %h expected %h", got, e.exp);
            else passed++;
            @(posedge clk); @(negedge clk);
        end
        e = sb.pop_front();
        #1;
        got = observed();
        checks++;
        if (got !== e.exp) $display("FAIL midreset_memwr: got %h expected %h", got, e.exp);
        else passed++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.state_dbg, bus.memwrite, bus.regwrite, bus.pcen, bus.irwrite} !== 8'b0)
            $display("FAIL midreset_kill: got %b expected %b",
                     {bus.state_dbg, bus.memwrite, bus.regwrite, bus.pcen, bus.irwrite}, 8'b0);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        got = observed();
        checks++;
        if (got !== outs(ST_FETCH, 3'b000, 1'b0))
            $display("FAIL midreset_release: got %h expected %h", got, outs(ST_FETCH, 3'b000, 1'b0));
        else passed++;
    endtask

    task automatic test_back_to_back();
        sb_t e;
        logic [18:0] got;
        push(6'b101011, 6'b0, 1'b0, ST_FETCH, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_DECODE, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_MEMADR, 3'b000);
        push(6'b101011, 6'b0, 1'b0, ST_MEMWR, 3'b000);
        push(6'b000010, 6'b0, 1'b0, ST_FETCH, 3'b000);
        push(6'b000010, 6'b0, 1'b0, ST_DECODE, 3'b000);
        push(6'b000010, 6'b0, 1'b0, ST_JUMP, 3'b000);
        push(6'b000010, 6'b0, 1'b0, ST_FETCH, 3'b000);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            bus.op = e.op; bus.funct = e.funct; bus.zero = e.z;
            #1;
            got = observed();
            checks++;
            if (got !== e.exp) $display("FAIL sw_j step %0d: got %h expected %h", i, got, e.exp);
            else passed++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_illegal();
        test_reset_midwrite();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
